// File: rtl/multi_cycle_ctrl.sv
// rtl/multi_cycle_ctrl.sv - multi-cycle RV32I sequencer: per-cycle enables, shared memory handshake, counters.
// Optional macro MULTI_CYCLE_ILLEGAL_EN: unknown opcodes trap instead of retiring as NOP.
module multi_cycle_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       opcode,
    input  logic             mem_ready,
    output logic             ir_write,
    output logic             pc_write,
    output logic             mem_req,
    output logic             mem_sel,
    output logic             mem_we,
    output logic             rf_write,
    output logic             halted,
    output logic             illegal,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] instret,
    output logic [CNT_W-1:0] cycles
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5,
        S_TRAP   = 3'd6
    } state_t;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_instret;
    logic [CNT_W-1:0] r_cycles;
    logic             w_known;
    logic             w_is_store;
    logic             w_ir_write;
    logic             w_pc_write;
    logic             w_mem_req;
    logic             w_mem_sel;
    logic             w_mem_we;
    logic             w_rf_write;

    always_comb begin
        w_known = 1'b0;
        case (opcode)
            OPC_LOAD, OPC_STORE, OPC_BRANCH, OPC_OP, OPC_OPIMM,
            OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR: w_known = 1'b1;
            default:                               w_known = 1'b0;
        endcase
    end

    assign w_is_store = (opcode == OPC_STORE);

    always_comb begin
        w_next     = r_state;
        w_ir_write = 1'b0;
        w_pc_write = 1'b0;
        w_mem_req  = 1'b0;
        w_mem_sel  = 1'b0;
        w_mem_we   = 1'b0;
        w_rf_write = 1'b0;
        case (r_state)
            S_FETCH: begin
                w_mem_req = 1'b1;
                if (mem_ready) begin
                    w_ir_write = 1'b1;
                    w_next     = S_DECODE;
                end
            end
            S_DECODE: begin
                if (opcode == OPC_SYSTEM) begin
                    w_next = S_HALT;
                end else if (w_known) begin
                    w_next = S_EXEC;
                end else begin
`ifdef MULTI_CYCLE_ILLEGAL_EN
                    w_next = S_TRAP;
`else
                    w_pc_write = 1'b1;
                    w_next     = S_FETCH;
`endif
                end
            end
            S_EXEC: begin
                case (opcode)
                    OPC_LOAD, OPC_STORE: w_next = S_MEM;
                    OPC_BRANCH: begin
                        w_pc_write = 1'b1;
                        w_next     = S_FETCH;
                    end
                    default:             w_next = S_WB;
                endcase
            end
            S_MEM: begin
                // Request attributes depend only on state and IR opcode, so they hold steady across waits.
                w_mem_req = 1'b1;
                w_mem_sel = 1'b1;
                w_mem_we  = w_is_store;
                if (mem_ready) begin
                    if (w_is_store) begin
                        w_pc_write = 1'b1;
                        w_next     = S_FETCH;
                    end else begin
                        w_next = S_WB;
                    end
                end
            end
            S_WB: begin
                w_rf_write = 1'b1;
                w_pc_write = 1'b1;
                w_next     = S_FETCH;
            end
            S_HALT:  w_next = S_HALT;
            S_TRAP:  w_next = S_TRAP;
            default: w_next = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_FETCH;
            r_instret <= '0;
            r_cycles  <= '0;
        end else begin
            r_state <= w_next;
            if (w_pc_write) begin
                r_instret <= r_instret + CNT_ONE;
            end
            if ((r_state != S_HALT) && (r_state != S_TRAP)) begin
                r_cycles <= r_cycles + CNT_ONE;
            end
        end
    end

    // Reset masks every enable so an in-flight request is withdrawn in the reset cycle itself.
    assign ir_write = w_ir_write & ~rst;
    assign pc_write = w_pc_write & ~rst;
    assign mem_req  = w_mem_req  & ~rst;
    assign mem_sel  = w_mem_sel  & ~rst;
    assign mem_we   = w_mem_we   & ~rst;
    assign rf_write = w_rf_write & ~rst;
    assign halted   = (r_state == S_HALT) & ~rst;
`ifdef MULTI_CYCLE_ILLEGAL_EN
    assign illegal  = (r_state == S_TRAP) & ~rst;
`else
    assign illegal  = 1'b0;
`endif
    assign state    = r_state;
    assign instret  = r_instret;
    assign cycles   = r_cycles;

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// tb/tb_multi_cycle_ctrl.sv - directed self-checking bench for multi_cycle_ctrl.
module tb_multi_cycle_ctrl;

    logic        clk;
    logic        rst;
    logic [6:0]  opcode;
    logic        mem_ready;
    logic        ir_write;
    logic        pc_write;
    logic        mem_req;
    logic        mem_sel;
    logic        mem_we;
    logic        rf_write;
    logic        halted;
    logic        illegal;
    logic [2:0]  state;
    logic [31:0] instret;
    logic [31:0] cycles;

    int total = 0;
    int bad   = 0;

    multi_cycle_ctrl #(.CNT_W(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .opcode    (opcode),
        .mem_ready (mem_ready),
        .ir_write  (ir_write),
        .pc_write  (pc_write),
        .mem_req   (mem_req),
        .mem_sel   (mem_sel),
        .mem_we    (mem_we),
        .rf_write  (rf_write),
        .halted    (halted),
        .illegal   (illegal),
        .state     (state),
        .instret   (instret),
        .cycles    (cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change on the falling edge, checks follow 1 time unit later.
    task automatic cyc(input logic mr);
        @(negedge clk);
        mem_ready = mr;
        #1;
    endtask

    task automatic do_reset(input logic mr);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_mem_req", {31'b0, mem_req}, 32'd0);
        chk("rst_halted", {31'b0, halted}, 32'd0);
        @(negedge clk);
        rst       = 1'b0;
        mem_ready = mr;
        #1;
    endtask

    initial begin
        rst       = 1'b1;
        opcode    = 7'b0010011;
        mem_ready = 1'b1;

        // Reset cycle: all enables low even though FETCH would request
        @(negedge clk);
        #1;
        chk("reset_state", {29'b0, state}, 32'd0);
        chk("reset_mem_req", {31'b0, mem_req}, 32'd0);
        chk("reset_ir_write", {31'b0, ir_write}, 32'd0);
        chk("reset_instret", instret, 32'd0);
        chk("reset_cycles", cycles, 32'd0);
        chk("reset_halted", {31'b0, halted}, 32'd0);
        chk("reset_illegal", {31'b0, illegal}, 32'd0);

        // addi, zero-wait: 0,1,2,4,0
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("addi_fetch_state", {29'b0, state}, 32'd0);
        chk("addi_fetch_req", {30'b0, mem_req, mem_sel}, 32'b10);
        chk("addi_fetch_irw", {31'b0, ir_write}, 32'd1);
        chk("addi_fetch_cycles", cycles, 32'd0);
        cyc(1'b1);
        chk("addi_decode_state", {29'b0, state}, 32'd1);
        chk("addi_decode_req", {31'b0, mem_req}, 32'd0);
        chk("addi_decode_irw", {31'b0, ir_write}, 32'd0);
        cyc(1'b1);
        chk("addi_exec_state", {29'b0, state}, 32'd2);
        chk("addi_exec_rfw", {31'b0, rf_write}, 32'd0);
        cyc(1'b1);
        chk("addi_wb_state", {29'b0, state}, 32'd4);
        chk("addi_wb_rfw_pcw", {30'b0, rf_write, pc_write}, 32'b11);
        chk("addi_wb_instret", instret, 32'd0);
        chk("addi_wb_cycles", cycles, 32'd3);
        cyc(1'b1);
        chk("addi_done_state", {29'b0, state}, 32'd0);
        chk("addi_done_instret", instret, 32'd1);
        chk("addi_done_cycles", cycles, 32'd4);
        chk("addi_done_rfw", {31'b0, rf_write}, 32'd0);

        // lw with two wait cycles in MEM
        opcode = 7'b0000011;
        cyc(1'b1);
        chk("lw_decode_state", {29'b0, state}, 32'd1);
        cyc(1'b1);
        chk("lw_exec_state", {29'b0, state}, 32'd2);
        cyc(1'b0);
        chk("lw_mem1_state", {29'b0, state}, 32'd3);
        chk("lw_mem1_req", {29'b0, mem_req, mem_sel, mem_we}, 32'b110);
        chk("lw_mem1_pcw", {31'b0, pc_write}, 32'd0);
        chk("lw_mem1_cycles", cycles, 32'd7);
        cyc(1'b0);
        chk("lw_mem2_state", {29'b0, state}, 32'd3);
        chk("lw_mem2_req", {29'b0, mem_req, mem_sel, mem_we}, 32'b110);
        cyc(1'b1);
        chk("lw_mem3_state", {29'b0, state}, 32'd3);
        chk("lw_mem3_req", {29'b0, mem_req, mem_sel, mem_we}, 32'b110);
        cyc(1'b1);
        chk("lw_wb_state", {29'b0, state}, 32'd4);
        chk("lw_wb_rfw", {31'b0, rf_write}, 32'd1);
        chk("lw_wb_cycles", cycles, 32'd10);
        cyc(1'b1);
        chk("lw_done_instret", instret, 32'd2);
        chk("lw_done_cycles", cycles, 32'd11);

        // sw, zero-wait
        opcode = 7'b0100011;
        chk("sw_fetch_irw", {31'b0, ir_write}, 32'd1);
        cyc(1'b1);
        cyc(1'b1);
        chk("sw_exec_state", {29'b0, state}, 32'd2);
        cyc(1'b1);
        chk("sw_mem_state", {29'b0, state}, 32'd3);
        chk("sw_mem_req", {29'b0, mem_req, mem_sel, mem_we}, 32'b111);
        chk("sw_mem_pcw_rfw", {30'b0, pc_write, rf_write}, 32'b10);
        cyc(1'b1);
        chk("sw_done_state", {29'b0, state}, 32'd0);
        chk("sw_done_we", {31'b0, mem_we}, 32'd0);
        chk("sw_done_instret", instret, 32'd3);
        chk("sw_done_cycles", cycles, 32'd15);

        // beq then ecall
        opcode = 7'b1100011;
        cyc(1'b1);
        cyc(1'b1);
        chk("beq_exec_state", {29'b0, state}, 32'd2);
        chk("beq_exec_pcw", {31'b0, pc_write}, 32'd1);
        cyc(1'b1);
        chk("beq_done_state", {29'b0, state}, 32'd0);
        chk("beq_done_instret", instret, 32'd4);
        chk("beq_done_cycles", cycles, 32'd18);
        opcode = 7'b1110011;
        cyc(1'b1);
        chk("ecall_decode_state", {29'b0, state}, 32'd1);
        chk("ecall_decode_pcw", {31'b0, pc_write}, 32'd0);
        cyc(1'b1);
        chk("halt_state", {29'b0, state}, 32'd5);
        chk("halt_halted", {31'b0, halted}, 32'd1);
        chk("halt_mem_req", {31'b0, mem_req}, 32'd0);
        chk("halt_cycles", cycles, 32'd20);
        cyc(1'b1);
        chk("halt_hold_state", {29'b0, state}, 32'd5);
        chk("halt_hold_cycles", cycles, 32'd20);
        chk("halt_hold_instret", instret, 32'd4);
        chk("halt_hold_enables", {26'b0, ir_write, pc_write, mem_req, mem_sel, mem_we, rf_write}, 32'd0);

        // Unknown opcode 0000000
        opcode = 7'b0000000;
        do_reset(1'b1);
        chk("ill_fetch_cycles", cycles, 32'd0);
        chk("ill_fetch_instret", instret, 32'd0);
        chk("ill_fetch_halted", {31'b0, halted}, 32'd0);
        cyc(1'b1);
        chk("ill_decode_state", {29'b0, state}, 32'd1);
`ifdef MULTI_CYCLE_ILLEGAL_EN
        chk("ill_decode_pcw", {31'b0, pc_write}, 32'd0);
        cyc(1'b1);
        chk("ill_trap_state", {29'b0, state}, 32'd6);
        chk("ill_trap_illegal", {31'b0, illegal}, 32'd1);
        chk("ill_trap_cycles", cycles, 32'd2);
        cyc(1'b1);
        chk("ill_trap_hold_cycles", cycles, 32'd2);
        chk("ill_trap_hold_req", {31'b0, mem_req}, 32'd0);
        chk("ill_trap_instret", instret, 32'd0);
`else
        chk("nop_decode_pcw", {31'b0, pc_write}, 32'd1);
        cyc(1'b1);
        chk("nop_state", {29'b0, state}, 32'd0);
        chk("nop_instret", instret, 32'd1);
        chk("nop_cycles", cycles, 32'd2);
        chk("nop_illegal", {31'b0, illegal}, 32'd0);
`endif

        // Reset while FETCH is waiting
        opcode = 7'b0010011;
        do_reset(1'b0);
        chk("wait_fetch_req", {31'b0, mem_req}, 32'd1);
        chk("wait_fetch_irw", {31'b0, ir_write}, 32'd0);
        cyc(1'b0);
        chk("wait_fetch_state", {29'b0, state}, 32'd0);
        cyc(1'b0);
        chk("wait_fetch_cycles", cycles, 32'd2);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_mem_req", {31'b0, mem_req}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("midrst_state", {29'b0, state}, 32'd0);
        chk("midrst_cycles", cycles, 32'd0);
        chk("midrst_instret", instret, 32'd0);
        chk("midrst_mem_req_after", {31'b0, mem_req}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
